uc_multiciclo: RTL and testbench

- Multicycle control unit that drives the `microc` datapath.
- Consumes the datapath's `opcode` and `z` flag; produces `s_inc`, `s_inm`, `we3`, `op`, plus a PC write enable.
- Sequences each instruction through FETCH and EXEC states, supports a datapath stall and a sticky HALT.
- Sits beside `microc` in the top-level `cpu`, replacing the free-running combinational decode.

---
 rtl/uc_multiciclo_pkg.sv | 28 ++
 rtl/uc_multiciclo_if.sv | 29 ++
 rtl/uc_multiciclo_decode.sv | 33 +++
 rtl/uc_multiciclo.sv | 70 +++++++
 tb/tb_uc_multiciclo.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uc_multiciclo_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// opcode/class constants and the decoded control bundle.
package uc_multiciclo_pkg;
    localparam int OPW  = 6;
    localparam int ALUW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0]     CL_ALU  = 2'b00;
    localparam logic [1:0]     CL_LI   = 2'b01;
    localparam logic [OPW-1:0] OP_J    = 6'b100000;
    localparam logic [OPW-1:0] OP_JZ   = 6'b100001;
    localparam logic [OPW-1:0] OP_JNZ  = 6'b100010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    typedef struct packed {
        logic            s_inc;
        logic            s_inm;
        logic            we3;
        logic [ALUW-1:0] op;
        logic            is_halt;
    } ctrl_t;
endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
// UC_RETIRE_CNT_EN adds the retired-instruction counter output.
interface uc_multiciclo_if #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
);
    logic [OPW-1:0]  opcode;
    logic            z;
    logic            stall;
    logic            pc_en;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic [ALUW-1:0] op;
    logic            halted;
`ifdef UC_RETIRE_CNT_EN
    logic [15:0]     retired;

    modport master (input opcode, z, stall,
                    output pc_en, s_inc, s_inm, we3, op, halted, retired);
    modport slave  (output opcode, z, stall,
                    input pc_en, s_inc, s_inm, we3, op, halted, retired);
`else
    modport master (input opcode, z, stall,
                    output pc_en, s_inc, s_inm, we3, op, halted);
    modport slave  (output opcode, z, stall,
                    input pc_en, s_inc, s_inm, we3, op, halted);
`endif
endinterface

// File: rtl/uc_multiciclo_decode.sv
// Pure combinational instruction decode: (ir, z) -> datapath controls.
// Unknown codes in the 10xxxx/11xxxx space fall through as NOPs.
module uc_decode
    import uc_multiciclo_pkg::*;
(
    input  logic [OPW-1:0] ir,
    input  logic           z,
    output ctrl_t          ctrl
);
    always_comb begin
        ctrl       = '0;
        ctrl.s_inc = 1'b1;
        case (ir[5:4])
            CL_ALU: begin
                ctrl.op  = ir[ALUW-1:0];
                ctrl.we3 = 1'b1;
            end
            CL_LI: begin
                ctrl.s_inm = 1'b1;
                ctrl.we3   = 1'b1;
            end
            default: begin
                case (ir)
                    OP_J:    ctrl.s_inc   = 1'b0;
                    OP_JZ:   ctrl.s_inc   = ~z;
                    OP_JNZ:  ctrl.s_inc   = z;
                    OP_HALT: ctrl.is_halt = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the microc datapath: IDLE -> FETCH -> EXEC loop
// with stall hold and sticky HALT. UC_RETIRE_CNT_EN adds a retired counter.
module uc_multiciclo
    import uc_multiciclo_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    uc_multiciclo_if.master bus
);
    state_t         state_q, state_d;
    logic [OPW-1:0] ir_q, ir_d;
    ctrl_t          dec;
    logic           in_exec;
    logic           retire;

    uc_decode u_decode (
        .ir   (ir_q),
        .z    (bus.z),
        .ctrl (dec)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                ir_d    = bus.opcode;
                state_d = EXEC;
            end
            EXEC:  if (!bus.stall) state_d = dec.is_halt ? HALT : FETCH;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs depend only on state/ir, except the write strobes (gated by stall)
    // and the JZ/JNZ select (follows z while in EXEC).
    assign in_exec    = (state_q == EXEC);
    assign retire     = in_exec && !bus.stall && !dec.is_halt;
    assign bus.pc_en  = retire;
    assign bus.we3    = in_exec && !bus.stall && dec.we3;
    assign bus.s_inc  = in_exec ? dec.s_inc : 1'b1;
    assign bus.s_inm  = in_exec && dec.s_inm;
    assign bus.op     = in_exec ? dec.op : '0;
    assign bus.halted = (state_q == HALT);

`ifdef UC_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb retired_d = retired_q + {15'd0, retire};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign bus.retired = retired_q;
`endif
endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed scenarios plus randomized
// instruction streams compared against an opcode-level reference model.
module tb_uc_multiciclo;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   exp_ret  = 0;

    localparam logic [7:0] INACT  = 8'b0010_0000; // {pc_en,we3,s_inc,s_inm,op,halted}
    localparam logic [7:0] HALTED = 8'b0010_0001;

    uc_multiciclo_if bus ();
    uc_multiciclo dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {bus.pc_en, bus.we3, bus.s_inc, bus.s_inm, bus.op, bus.halted};
    endfunction

    // Instruction semantics by opcode value range: 0-15 ALU, 16-31 LI,
    // 32 J, 33 JZ, 34 JNZ, 63 HALT, anything else NOP.
    function automatic logic [7:0] model(logic [5:0] opc, logic zz);
        logic pc, we, inc, inm;
        logic [2:0] alu;
        pc = 1'b1; we = 1'b0; inc = 1'b1; inm = 1'b0; alu = 3'd0;
        if (opc < 6'd16) begin
            we = 1'b1; alu = 3'(opc % 8);
        end else if (opc < 6'd32) begin
            we = 1'b1; inm = 1'b1;
        end else if (opc == 6'd32) inc = 1'b0;
        else if (opc == 6'd33) inc = !zz;
        else if (opc == 6'd34) inc = zz;
        else if (opc == 6'd63) pc = 1'b0;
        return {pc, we, inc, inm, alu, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Entered 1ns after the edge that put the FSM in FETCH.
    task automatic run_instr(input logic [5:0] opc, input logic zz, input int nstall,
                             input string nm);
        logic [7:0] e, es;
        logic zs;
        bus.opcode = opc;
        bus.z      = 1'($urandom);
        bus.stall  = 1'($urandom);
        #1;
        checks++;
        if (obs() !== INACT) begin
            failures++;
            $display("FAIL %s fetch: got %b want %b", nm, obs(), INACT);
        end
        bus.stall = 1'b0;
        tick();
        bus.opcode = 6'($urandom);  // ir was captured at the FETCH edge
        for (int i = 0; i < nstall; i++) begin
            zs = 1'($urandom);
            bus.z = zs;
            bus.stall = 1'b1;
            es = model(opc, zs);
            #1;
            checks++;
            if (obs() !== {2'b00, es[5:0]}) begin
                failures++;
                $display("FAIL %s stall%0d: got %b want %b", nm, i, obs(), {2'b00, es[5:0]});
            end
            tick();
        end
        bus.stall = 1'b0;
        bus.z     = zz;
        e = model(opc, zz);
        #1;
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL %s exec: got %b want %b", nm, obs(), e);
        end
        tick();
        if (opc != 6'd63) exp_ret++;
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (bus.retired !== 16'(exp_ret)) begin
            failures++;
            $display("FAIL %s retired: got %0d want %0d", nm, bus.retired, exp_ret);
        end
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== INACT) begin
            failures++;
            $display("FAIL apply_reset: got %b want %b", obs(), INACT);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (obs() !== INACT) begin
            failures++;
            $display("FAIL reset_held: got %b want %b", obs(), INACT);
        end
        #4 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== INACT) begin
            failures++;
            $display("FAIL idle: got %b want %b", obs(), INACT);
        end
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (bus.retired !== 16'd0) begin
            failures++;
            $display("FAIL retired_reset: got %0d want 0", bus.retired);
        end
`endif
        tick();
    endtask

    task automatic test_alu_li();
        run_instr(6'b000101, 1'b0, 0, "alu");
        run_instr(6'b010000, 1'b1, 0, "li");
        run_instr(6'b000000, 1'b0, 0, "alu0");
    endtask

    task automatic test_jumps();
        run_instr(6'b100001, 1'b1, 0, "jz_z1");
        run_instr(6'b100001, 1'b0, 0, "jz_z0");
        run_instr(6'b100010, 1'b0, 0, "jnz_z0");
        run_instr(6'b100010, 1'b1, 0, "jnz_z1");
        run_instr(6'b100000, 1'b0, 0, "j_z0");
        run_instr(6'b100000, 1'b1, 0, "j_z1");
        run_instr(6'b101100, 1'b1, 0, "nop");
    endtask

    task automatic test_stall();
        run_instr(6'b000101, 1'b0, 3, "alu_stall3");
        run_instr(6'b100001, 1'b1, 2, "jz_stall2");
    endtask

    task automatic test_random();
        logic [5:0] opc;
        for (int n = 0; n < 40; n++) begin
            opc = 6'($urandom);
            if (opc == 6'd63) opc = 6'd62;
            run_instr(opc, 1'($urandom), int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_retire();
        apply_reset();
        run_instr(6'b000011, 1'b0, 0, "ret_alu");
        run_instr(6'b010101, 1'b0, 1, "ret_li");
        run_instr(6'b100010, 1'b1, 0, "ret_jnz");
`ifdef UC_RETIRE_CNT_EN
        checks++;
        if (bus.retired !== 16'd3) begin
            failures++;
            $display("FAIL retire_seq: got %0d want 3", bus.retired);
        end
`endif
    endtask

    task automatic test_halt();
        run_instr(6'b111111, 1'b0, 1, "halt");
        for (int i = 0; i < 10; i++) begin
            bus.stall = 1'($urandom);
            bus.z     = 1'($urandom);
            #1;
            checks++;
            if (obs() !== HALTED) begin
                failures++;
                $display("FAIL halt_sticky%0d: got %b want %b", i, obs(), HALTED);
            end
            tick();
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        bus.opcode = 6'b000111;
        bus.z      = 1'b0;
        tick();
        #1;
        checks++;
        if (obs() !== 8'b1110_1110) begin
            failures++;
            $display("FAIL mid_exec_pre: got %b want %b", obs(), 8'b1110_1110);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs() !== INACT) begin
            failures++;
            $display("FAIL mid_exec_reset: got %b want %b", obs(), INACT);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 0;
        tick();
        run_instr(6'b001010, 1'b0, 0, "after_reset");
    endtask

    initial begin
        bus.opcode = '0;
        bus.z      = 1'b0;
        bus.stall  = 1'b0;
        test_reset();
        test_alu_li();
        test_jumps();
        test_stall();
        test_random();
        test_retire();
        test_halt();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
